// File: rtl/sopc_mem_arbiter.sv
// Shares one single-ported memory between the CPU fetch and data ports, with wait states and stalls.
// Optional grant/conflict statistics are compiled in when SOPC_ARB_STATS_EN is defined.
module sopc_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_PRI    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_ce_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_data_o,
  output logic                if_stall_o,
  input  logic                dm_ce_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_sel_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_data_i,
  output logic [DATA_W-1:0]   dm_data_o,
  output logic                dm_stall_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_data_o,
  input  logic [DATA_W-1:0]   mem_data_i
`ifdef SOPC_ARB_STATS_EN
  ,
  output logic [31:0]         stat_if_cnt_o,
  output logic [31:0]         stat_dm_cnt_o,
  output logic [31:0]         stat_conflict_cnt_o
`endif
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                grant_reg, grant_next;  // 1 = data port
  logic                last_reg, last_next;    // port granted most recently, 1 = data port
  logic [ADDR_W-1:0]   req_addr_reg, req_addr_next;
  logic                req_we_reg, req_we_next;
  logic [SEL_W-1:0]    req_sel_reg, req_sel_next;
  logic [DATA_W-1:0]   req_wdata_reg, req_wdata_next;
  logic [DATA_W-1:0]   if_data_reg, if_data_next;
  logic [DATA_W-1:0]   dm_data_reg, dm_data_next;

  logic arb_en;
  logic pick_dm;
  logic do_grant;
  logic conflict;

  // The response cycle doubles as an arbitration slot so back-to-back accesses lose no cycle.
  always_comb begin
    arb_en   = (state_reg == IDLE) || (state_reg == RESP);
    conflict = arb_en & if_ce_i & dm_ce_i;
    do_grant = arb_en & (if_ce_i | dm_ce_i);
    if (DATA_PRI != 0) begin
      pick_dm = dm_ce_i;
    end else begin
      pick_dm = dm_ce_i & (~if_ce_i | ~last_reg);
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    grant_next     = grant_reg;
    last_next      = last_reg;
    req_addr_next  = req_addr_reg;
    req_we_next    = req_we_reg;
    req_sel_next   = req_sel_reg;
    req_wdata_next = req_wdata_reg;
    if_data_next   = if_data_reg;
    dm_data_next   = dm_data_reg;

    case (state_reg)
      IDLE, RESP: begin
        state_next = IDLE;
        if (do_grant) begin
          state_next = ACCESS;
          cnt_next   = 4'(WAIT_CYCLES);
          grant_next = pick_dm;
          last_next  = pick_dm;
          if (pick_dm) begin
            req_addr_next  = dm_addr_i;
            req_we_next    = dm_we_i;
            req_sel_next   = dm_sel_i;
            req_wdata_next = dm_data_i;
          end else begin
            req_addr_next  = if_addr_i;
            req_we_next    = 1'b0;
            req_sel_next   = '1;
            req_wdata_next = '0;
          end
        end
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          // A requester that gave up mid-access gets no data; writes never return data.
          if (!req_we_reg) begin
            if (grant_reg && dm_ce_i) begin
              dm_data_next = mem_data_i;
            end else if (!grant_reg && if_ce_i) begin
              if_data_next = mem_data_i;
            end
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      grant_reg     <= 1'b0;
      last_reg      <= 1'b0;
      req_addr_reg  <= '0;
      req_we_reg    <= 1'b0;
      req_sel_reg   <= '0;
      req_wdata_reg <= '0;
      if_data_reg   <= '0;
      dm_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      grant_reg     <= grant_next;
      last_reg      <= last_next;
      req_addr_reg  <= req_addr_next;
      req_we_reg    <= req_we_next;
      req_sel_reg   <= req_sel_next;
      req_wdata_reg <= req_wdata_next;
      if_data_reg   <= if_data_next;
      dm_data_reg   <= dm_data_next;
    end
  end

  always_comb begin
    mem_ce_o   = (state_reg == ACCESS);
    mem_we_o   = mem_ce_o & req_we_reg;
    mem_sel_o  = mem_ce_o ? req_sel_reg : '0;
    mem_addr_o = mem_ce_o ? req_addr_reg : '0;
    mem_data_o = mem_ce_o ? req_wdata_reg : '0;
    if_stall_o = if_ce_i & ~((state_reg == RESP) & ~grant_reg);
    dm_stall_o = dm_ce_i & ~((state_reg == RESP) & grant_reg);
  end

  assign if_data_o = if_data_reg;
  assign dm_data_o = dm_data_reg;

`ifdef SOPC_ARB_STATS_EN
  logic [31:0] stat_if_reg, stat_dm_reg, stat_conflict_reg;

  // Counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_reg       <= '0;
      stat_dm_reg       <= '0;
      stat_conflict_reg <= '0;
    end else begin
      if (do_grant && !pick_dm && stat_if_reg != 32'hFFFF_FFFF) begin
        stat_if_reg <= stat_if_reg + 32'd1;
      end
      if (do_grant && pick_dm && stat_dm_reg != 32'hFFFF_FFFF) begin
        stat_dm_reg <= stat_dm_reg + 32'd1;
      end
      if (conflict && stat_conflict_reg != 32'hFFFF_FFFF) begin
        stat_conflict_reg <= stat_conflict_reg + 32'd1;
      end
    end
  end

  assign stat_if_cnt_o       = stat_if_reg;
  assign stat_dm_cnt_o       = stat_dm_reg;
  assign stat_conflict_cnt_o = stat_conflict_reg;
`endif

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Bench for sopc_mem_arbiter: instance 0 has one wait state and data priority, instance 1 has
// zero wait states and round-robin; both are checked every cycle against a transaction-level model.
module tb_sopc_mem_arbiter;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_ce   [NI];
  logic [31:0] if_addr [NI];
  logic [31:0] if_do   [NI];
  logic        if_st   [NI];
  logic        dm_ce   [NI];
  logic        dm_we   [NI];
  logic [3:0]  dm_sel  [NI];
  logic [31:0] dm_addr [NI];
  logic [31:0] dm_wd   [NI];
  logic [31:0] dm_do   [NI];
  logic        dm_st   [NI];
  logic        mem_ce  [NI];
  logic        mem_we  [NI];
  logic [3:0]  mem_sel [NI];
  logic [31:0] mem_addr[NI];
  logic [31:0] mem_do  [NI];
  logic [31:0] mem_di  [NI];
  logic [31:0] mem_real[NI][256];
`ifdef SOPC_ARB_STATS_EN
  logic [31:0] st_if[NI], st_dm[NI], st_cf[NI];
`endif

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    sopc_mem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .WAIT_CYCLES(gi == 0 ? 1 : 0),
      .DATA_PRI   (gi == 0 ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_ce_i   (if_ce[gi]),
      .if_addr_i (if_addr[gi]),
      .if_data_o (if_do[gi]),
      .if_stall_o(if_st[gi]),
      .dm_ce_i   (dm_ce[gi]),
      .dm_we_i   (dm_we[gi]),
      .dm_sel_i  (dm_sel[gi]),
      .dm_addr_i (dm_addr[gi]),
      .dm_data_i (dm_wd[gi]),
      .dm_data_o (dm_do[gi]),
      .dm_stall_o(dm_st[gi]),
      .mem_ce_o  (mem_ce[gi]),
      .mem_we_o  (mem_we[gi]),
      .mem_sel_o (mem_sel[gi]),
      .mem_addr_o(mem_addr[gi]),
      .mem_data_o(mem_do[gi]),
      .mem_data_i(mem_di[gi])
`ifdef SOPC_ARB_STATS_EN
      ,
      .stat_if_cnt_o      (st_if[gi]),
      .stat_dm_cnt_o      (st_dm[gi]),
      .stat_conflict_cnt_o(st_cf[gi])
`endif
    );
    assign mem_di[gi] = mem_real[gi][mem_addr[gi][9:2]];
  end

  function automatic logic [31:0] iw(int i);
    logic [31:0] v;
    v = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    return (i == 4) ? 32'h3401_1100 : v;
  endfunction

  // Unified ROM/RAM: combinational read, byte-enabled write on the strobe.
  initial begin
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 256; i++) mem_real[k][i] = iw(i);
    forever begin
      @(posedge clk);
      for (int k = 0; k < NI; k++)
        if (mem_ce[k] && mem_we[k])
          for (int b = 0; b < 4; b++)
            if (mem_sel[k][b]) mem_real[k][mem_addr[k][9:2]][8*b +: 8] <= mem_do[k][8*b +: 8];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Model: the arbiter is either free or busy with one transaction for WAIT+1 memory cycles,
  // followed by one response cycle in which it is free to accept the next request.
  function automatic int wc(int k);
    return (k == 0) ? 1 : 0;
  endfunction
  function automatic bit pri(int k);
    return k == 0;
  endfunction

  int          acc_left[NI];
  bit          resp_m[NI], gp[NI], lastp[NI], l_we[NI];
  logic [31:0] l_addr[NI], l_wd[NI], e_ifd[NI], e_dmd[NI];
  logic [3:0]  l_sel[NI];
  logic [31:0] mm[NI][256];
`ifdef SOPC_ARB_STATS_EN
  logic [31:0] m_if[NI], m_dm[NI], m_cf[NI];
`endif

  initial begin
    bit a;
    bit d;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 256; i++) mm[k][i] = iw(i);
      acc_left[k] = 0; resp_m[k] = 0; gp[k] = 0; lastp[k] = 0; l_we[k] = 0;
      l_addr[k] = 0; l_wd[k] = 0; l_sel[k] = 0; e_ifd[k] = 0; e_dmd[k] = 0;
`ifdef SOPC_ARB_STATS_EN
      m_if[k] = 0; m_dm[k] = 0; m_cf[k] = 0;
`endif
    end
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < NI; k++) begin
          a = (acc_left[k] > 0);
          chk($sformatf("i%0d mem_ce", k), 32'(mem_ce[k]), 32'(a));
          chk($sformatf("i%0d mem_we", k), 32'(mem_we[k]), 32'(a & l_we[k]));
          chk($sformatf("i%0d mem_sel", k), 32'(mem_sel[k]), a ? 32'(l_sel[k]) : 32'd0);
          chk($sformatf("i%0d mem_addr", k), mem_addr[k], a ? l_addr[k] : 32'd0);
          chk($sformatf("i%0d mem_data", k), mem_do[k], a ? l_wd[k] : 32'd0);
          chk($sformatf("i%0d if_stall", k), 32'(if_st[k]), 32'(if_ce[k] & ~(resp_m[k] & ~gp[k])));
          chk($sformatf("i%0d dm_stall", k), 32'(dm_st[k]), 32'(dm_ce[k] & ~(resp_m[k] & gp[k])));
          chk($sformatf("i%0d if_data", k), if_do[k], e_ifd[k]);
          chk($sformatf("i%0d dm_data", k), dm_do[k], e_dmd[k]);
`ifdef SOPC_ARB_STATS_EN
          chk($sformatf("i%0d stat_if", k), st_if[k], m_if[k]);
          chk($sformatf("i%0d stat_dm", k), st_dm[k], m_dm[k]);
          chk($sformatf("i%0d stat_cf", k), st_cf[k], m_cf[k]);
`endif
        end
      end
      @(posedge clk);
      for (int k = 0; k < NI; k++) begin
        if (acc_left[k] > 0 && l_we[k])
          for (int b = 0; b < 4; b++)
            if (l_sel[k][b]) mm[k][l_addr[k][9:2]][8*b +: 8] = l_wd[k][8*b +: 8];
        if (rst) begin
          acc_left[k] = 0; resp_m[k] = 0; gp[k] = 0; lastp[k] = 0;
          e_ifd[k] = 0; e_dmd[k] = 0;
`ifdef SOPC_ARB_STATS_EN
          m_if[k] = 0; m_dm[k] = 0; m_cf[k] = 0;
`endif
        end else if (acc_left[k] > 0) begin
          acc_left[k]--;
          if (acc_left[k] == 0) begin
            resp_m[k] = 1;
            if (!l_we[k]) begin
              if (gp[k] && dm_ce[k]) e_dmd[k] = mm[k][l_addr[k][9:2]];
              else if (!gp[k] && if_ce[k]) e_ifd[k] = mm[k][l_addr[k][9:2]];
            end
          end
        end else begin
          resp_m[k] = 0;
          if (if_ce[k] || dm_ce[k]) begin
            d = dm_ce[k] && (pri(k) || !if_ce[k] || !lastp[k]);
            gp[k] = d; lastp[k] = d;
            l_addr[k] = d ? dm_addr[k] : if_addr[k];
            l_we[k]   = d ? dm_we[k] : 1'b0;
            l_sel[k]  = d ? dm_sel[k] : 4'hF;
            l_wd[k]   = d ? dm_wd[k] : 32'd0;
            acc_left[k] = wc(k) + 1;
`ifdef SOPC_ARB_STATS_EN
            if (d && m_dm[k] != 32'hFFFF_FFFF) m_dm[k]++;
            if (!d && m_if[k] != 32'hFFFF_FFFF) m_if[k]++;
            if (if_ce[k] && dm_ce[k] && m_cf[k] != 32'hFFFF_FFFF) m_cf[k]++;
`endif
          end
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic bit st(int k, bit dm);
    return dm ? dm_st[k] : if_st[k];
  endfunction

  // Counts cycles the stall stays high, starting with the current one; stops in the release cycle.
  task automatic stall_len(input int k, input bit dm, output int n);
    n = 0;
    while (st(k, dm) && n < 40) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    int n, t, tdm, tif, nwe, nce, nresp, cnt;
    logic [3:0] seq;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      if_ce[k] = 0; if_addr[k] = 0; dm_ce[k] = 0; dm_we[k] = 0;
      dm_sel[k] = 0; dm_addr[k] = 0; dm_wd[k] = 0;
    end
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("reset mem_ce", 32'(mem_ce[0]), 32'd0);
    chk("reset if_data", if_do[0], 32'd0);
    chk("reset dm_data", dm_do[0], 32'd0);
    chk("reset if_stall", 32'(if_st[0]), 32'd0);
    rst = 1'b0;
    cyc();

    // Single fetch, one wait state.
    if_ce[0] = 1; if_addr[0] = 32'h10; #1;
    stall_len(0, 0, n);
    chk("fetch stall cycles", 32'(n), 32'd3);
    chk("fetch data", if_do[0], 32'h3401_1100);
    if_ce[0] = 0;
    cyc();

    // Conflict with data priority.
    if_ce[0] = 1; if_addr[0] = 32'h10;
    dm_ce[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h10; dm_sel[0] = 4'hF; #1;
    t = 0; tdm = -1; tif = -1;
    while ((tdm < 0 || tif < 0) && t < 40) begin
      if (tdm < 0 && !dm_st[0]) begin tdm = t; dm_ce[0] = 0; end
      if (tif < 0 && !if_st[0]) begin tif = t; if_ce[0] = 0; end
      if (tdm < 0 || tif < 0) begin cyc(); t++; end
    end
    chk("prio dm release", 32'(tdm), 32'd3);
    chk("prio if after dm", 32'(tif - tdm), 32'd3);
    chk("prio dm data", dm_do[0], 32'h3401_1100);
    cyc();

    // Byte-enabled write.
    dm_ce[0] = 1; dm_we[0] = 1; dm_sel[0] = 4'b0011; dm_addr[0] = 32'h20; dm_wd[0] = 32'hDEAD_BEEF; #1;
    nwe = 0; t = 0;
    while (dm_st[0] && t < 40) begin
      cyc(); t++;
      if (mem_we[0]) nwe++;
    end
    dm_ce[0] = 0; dm_we[0] = 0;
    chk("write strobe cycles", 32'(nwe), 32'd2);
    chk("write keeps dm_data", dm_do[0], 32'h3401_1100);
    chk("write memory word", mem_real[0][8], {iw(8) >> 16, 16'hBEEF} & 32'hFFFF_FFFF);
    cyc();

    // Requester drops mid-access.
    dm_ce[0] = 1; dm_we[0] = 0; dm_sel[0] = 4'hF; dm_addr[0] = 32'h24; #1;
    cyc();
    dm_ce[0] = 0; #1;
    chk("drop stall low", 32'(dm_st[0]), 32'd0);
    cyc();
    chk("drop access completes", 32'(mem_ce[0]), 32'd1);
    cyc();
    chk("drop keeps dm_data", dm_do[0], 32'h3401_1100);
    cyc();

    // Reset during the second access cycle of a write.
    dm_ce[0] = 1; dm_we[0] = 1; dm_sel[0] = 4'hF; dm_addr[0] = 32'h28; dm_wd[0] = 32'h1234_5678; #1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst mem_ce", 32'(mem_ce[0]), 32'd0);
    chk("rst mem_we", 32'(mem_we[0]), 32'd0);
    chk("rst dm_stall follows ce", 32'(dm_st[0]), 32'd1);
    chk("rst if_stall follows ce", 32'(if_st[0]), 32'd0);
    chk("rst dm_data", dm_do[0], 32'd0);
    rst = 1'b0; dm_ce[0] = 0; dm_we[0] = 0;
    cyc();

    // Round-robin, zero wait states.
    dm_ce[1] = 1; dm_we[1] = 0; dm_sel[1] = 4'hF; dm_addr[1] = 32'h10; #1;
    stall_len(1, 1, n);
    chk("rr dm latency", 32'(n), 32'd2);
    dm_ce[1] = 0;
    cyc();
    if_ce[1] = 1; if_addr[1] = 32'h10; dm_ce[1] = 1; dm_addr[1] = 32'h14; #1;
    seq = 4'd0; cnt = 0; t = 0;
    while (cnt < 4 && t < 60) begin
      if (!if_st[1]) begin seq = {seq[2:0], 1'b0}; cnt++; end
      if (!dm_st[1]) begin seq = {seq[2:0], 1'b1}; cnt++; end
      if (cnt < 4) begin cyc(); t++; end
    end
    chk("rr grant order", 32'(seq), 32'h5);
`ifdef SOPC_ARB_STATS_EN
    chk("rr conflict count", st_cf[1], 32'd4);
    chk("rr if grants", st_if[1], 32'd2);
    chk("rr dm grants", st_dm[1], 32'd3);
`endif
    if_ce[1] = 0; dm_ce[1] = 0;
    chk("rr if data", if_do[1], 32'h3401_1100);
    chk("rr dm data", dm_do[1], iw(5));
    cyc();

    // Continuous fetch with zero wait states.
    if_ce[1] = 1; if_addr[1] = 32'h10; #1;
    nce = 0; nresp = 0;
    repeat (20) begin
      cyc();
      if (mem_ce[1]) nce++;
      if (!if_st[1]) nresp++;
    end
    if_ce[1] = 0;
    chk("stream mem_ce cycles", 32'(nce), 32'd10);
    chk("stream responses", 32'(nresp), 32'd10);
    cyc();

    // Randomized traffic on both instances.
    repeat (3000) begin
      cyc();
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < NI; k++) begin
        if_ce[k]   = ($urandom_range(0, 3) != 0);
        if_addr[k] = $urandom;
        dm_ce[k]   = ($urandom_range(0, 3) != 0);
        dm_we[k]   = ($urandom_range(0, 2) == 0);
        dm_sel[k]  = 4'($urandom);
        dm_addr[k] = $urandom;
        dm_wd[k]   = $urandom;
      end
    end
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
